e203_core_sleep_ctrl: RTL
=========================

E203_CORE_SLEEP_CTRL -- requirements
Module: e203_core_sleep_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_TMO, default 16: maximum number of DRAIN-state cycles before the WFI entry aborts (legal range 2..255).
REQ-002 SHALL have parameter WAKE_LAT, default 2: number of WAKE-state cycles before fetch restarts (legal range 1..15).
REQ-003 SHALL provide port clk, input, 1: the single clock.
REQ-004 SHALL provide port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL provide port wfi_req_valid, input, 1: a committed WFI instruction requests sleep entry.
REQ-006 SHALL provide port wfi_req_ready, output, 1: the sleep-entry request is accepted.
REQ-007 SHALL provide ports oitf_empty, lsu_idle and biu_idle, input, 1 each: pipeline-drain status.
REQ-008 SHALL provide ports irq_pend and dbg_req, input, 1 each: wake sources; wake_src = irq_pend | dbg_req.
REQ-009 SHALL provide port ifu_halt_req, output, 1: stops instruction fetch.
REQ-010 SHALL provide port core_wfi, output, 1: sleep indication driven to the clock controller.
REQ-011 SHALL provide port wake_valid, output, 1: a one-cycle pulse when fetch may resume.
REQ-012 SHALL provide port wfi_abort, output, 1: a one-cycle pulse when a sleep entry is cancelled.
REQ-013 SHALL provide port sleep_state, output, 2: the current state (RUN=0, DRAIN=1, SLEEP=2, WAKE=3).
REQ-014 SHALL provide port sleep_cycles, output, 16: the length of the last or current sleep, in cycles.

Function
REQ-015 SHALL implement a four-state FSM: RUN, DRAIN, SLEEP, WAKE.
REQ-016 SHALL drive wfi_req_ready = (state==RUN) & ~wake_src; wfi_req_ready is combinational and is never registered.
REQ-017 SHALL, in RUN, on wfi_req_valid & wfi_req_ready, enter DRAIN the next cycle and clear the drain counter to 0.
REQ-018 SHALL, in RUN with wake_src=1 and wfi_req_valid=1, not accept the request and stay in RUN.
REQ-019 SHALL, in DRAIN, give priority 1 to wake_src: go to RUN and pulse wfi_abort for 1 cycle.
REQ-020 SHALL, in DRAIN, give priority 2 to oitf_empty & lsu_idle & biu_idle, sampled in the same cycle: go to SLEEP and clear sleep_cycles to 0.
REQ-021 SHALL, in DRAIN, give priority 3 to drain counter == DRAIN_TMO-1: go to RUN and pulse wfi_abort.
REQ-022 SHALL, in DRAIN when no DRAIN transition occurs, increment the 8-bit drain counter.
REQ-023 SHALL, in SLEEP, increment sleep_cycles by 1 each cycle, saturating at 16'hFFFF with no wrap.
REQ-024 SHALL, in SLEEP, hold sleep_cycles in any state other than SLEEP, except for the clear in REQ-020.
REQ-025 SHALL, in SLEEP, go to WAKE on wake_src=1 and load a 4-bit wake counter with 0.
REQ-026 SHALL, in WAKE, increment the wake counter each cycle.
REQ-027 SHALL, in WAKE, go to RUN when wake counter == WAKE_LAT-1 and pulse wake_valid in that same cycle, which is the last WAKE cycle.
REQ-028 SHALL ignore wake_src while in WAKE; deassertion of wake_src does not cancel wake.
REQ-029 SHALL drive ifu_halt_req = 1 in DRAIN, SLEEP and WAKE, decoded from a registered state.
REQ-030 SHALL drive core_wfi = 1 only in SLEEP, registered, so that it is glitch-free to the clock gate.
REQ-031 SHALL keep wfi_abort and wake_valid mutually exclusive and never high on consecutive cycles.
REQ-032 SHALL ignore wfi_req_valid while not in RUN; no request is queued.

Reset
REQ-033 SHALL, on rst=1 (asynchronous), force state=RUN, drain counter=0, wake counter=0, sleep_cycles=0, wfi_abort=0, wake_valid=0.
REQ-034 SHALL, on rst=1, force core_wfi=0 and ifu_halt_req=0 immediately, without waiting for a clock edge.
REQ-035 SHALL, on reset asserted mid-SLEEP or mid-WAKE, drop core_wfi without emitting a wake_valid pulse.
REQ-036 SHALL resume normal operation on the first clk edge after rst deasserts.

Verification
REQ-037 SHALL verify normal sleep: request at cycle 0 with idle inputs high, irq_pend raised 10 cycles after entering SLEEP -> DRAIN 1 cycle, SLEEP 10 cycles, sleep_cycles=10, WAKE 2 cycles, wake_valid pulse, RUN.
REQ-038 SHALL verify drain timeout: lsu_idle held 0 -> exactly 16 DRAIN cycles, then wfi_abort pulse, then RUN with core_wfi never asserted.
REQ-039 SHALL verify abort in DRAIN: dbg_req on the 3rd DRAIN cycle with biu_idle=0 -> RUN next cycle, one wfi_abort, no wake_valid.
REQ-040 SHALL verify wake precedence: wfi_req_valid=1 together with irq_pend=1 in RUN -> wfi_req_ready=0 and state stays RUN.
REQ-041 SHALL verify saturation: 70000 cycles in SLEEP -> sleep_cycles=16'hFFFF, and the value is held after wake.
REQ-042 SHALL verify mid-sleep reset: rst pulsed in SLEEP -> core_wfi=0 asynchronously, state=RUN, sleep_cycles=0, no pulses.

Source files
------------

// File: rtl/e203_core_sleep_ctrl.sv
// WFI sleep controller: drains the pipeline, gates the core clock while asleep,
// and sequences the restart of instruction fetch when a wake source appears.
module e203_core_sleep_ctrl #(
   parameter int DRAIN_TMO = 16,
   parameter int WAKE_LAT  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wfi_req_valid,
   output logic        wfi_req_ready,
   input  logic        oitf_empty,
   input  logic        lsu_idle,
   input  logic        biu_idle,
   input  logic        irq_pend,
   input  logic        dbg_req,
   output logic        ifu_halt_req,
   output logic        core_wfi,
   output logic        wake_valid,
   output logic        wfi_abort,
   output logic [1:0]  sleep_state,
   output logic [15:0] sleep_cycles
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      SLEEP = 2'd2,
      WAKE  = 2'd3
   } state_t;

   localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_TMO - 1);
   localparam logic [3:0] WAKE_LAST  = 4'(WAKE_LAT - 1);

   state_t      state;
   logic [7:0]  drain_cnt;
   logic [3:0]  wake_cnt;
   logic [15:0] sleep_cnt;
   logic        core_wfi_q;
   logic        abort_q;
   logic        wake_valid_q;

   logic wake_src;
   logic all_idle;

   assign wake_src = irq_pend | dbg_req;
   assign all_idle = oitf_empty & lsu_idle & biu_idle;

   // A pending wake source blocks sleep entry outright rather than letting it abort later.
   assign wfi_req_ready = (state == RUN) & ~wake_src;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= RUN;
         drain_cnt    <= 8'd0;
         wake_cnt     <= 4'd0;
         sleep_cnt    <= 16'd0;
         core_wfi_q   <= 1'b0;
         abort_q      <= 1'b0;
         wake_valid_q <= 1'b0;
      end else begin
         abort_q      <= 1'b0;
         wake_valid_q <= 1'b0;
         case (state)
            RUN: begin
               if (wfi_req_valid & wfi_req_ready) begin
                  state     <= DRAIN;
                  drain_cnt <= 8'd0;
               end
            end
            DRAIN: begin
               if (wake_src) begin
                  state   <= RUN;
                  abort_q <= 1'b1;
               end else if (all_idle) begin
                  state      <= SLEEP;
                  sleep_cnt  <= 16'd0;
                  core_wfi_q <= 1'b1;
               end else if (drain_cnt == DRAIN_LAST) begin
                  state   <= RUN;
                  abort_q <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt + 8'd1;
               end
            end
            SLEEP: begin
               if (sleep_cnt != 16'hFFFF) begin
                  sleep_cnt <= sleep_cnt + 16'd1;
               end
               if (wake_src) begin
                  state        <= WAKE;
                  wake_cnt     <= 4'd0;
                  core_wfi_q   <= 1'b0;
                  // wake_valid is registered, so it is raised one edge early to land on the last WAKE cycle.
                  wake_valid_q <= (WAKE_LAST == 4'd0);
               end
            end
            WAKE: begin
               wake_cnt <= wake_cnt + 4'd1;
               if (wake_cnt == WAKE_LAST) begin
                  state <= RUN;
               end else begin
                  wake_valid_q <= ((wake_cnt + 4'd1) == WAKE_LAST);
               end
            end
         endcase
      end
   end

   assign ifu_halt_req = (state != RUN);
   assign core_wfi     = core_wfi_q;
   assign wfi_abort    = abort_q;
   assign wake_valid   = wake_valid_q;
   assign sleep_state  = state;
   assign sleep_cycles = sleep_cnt;

endmodule
